// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready request to APB3 master bridge.
// Single outstanding transfer. Back-to-back transfers are supported by accepting
// the next request in the completing ACCESS cycle.
// Optional build macro APB_TIMEOUT_EN: aborts an ACCESS phase that has waited
// TIMEOUT_CYCLES cycles and reports it as a slave error.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  accept;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
`else
  // The timeout limit has no effect when the abort logic is not built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Ready in IDLE, or in the ACCESS cycle that completes, so a follow-on request
  // can go straight to SETUP.
  assign req_ready = (state_q == IDLE) || ((state_q == ACCESS) && pready);
  assign accept    = req_valid && req_ready;

  // Next-state, captured request fields and response generation.
  always_comb begin
    state_d      = state_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          // Completion takes priority over a timeout reached in the same cycle.
          rsp_valid_d  = 1'b1;
          rsp_slverr_d = pslverr;
          rsp_rdata_d  = pwrite_q ? '0 : prdata;
          state_d      = accept ? SETUP : IDLE;
`ifdef APB_TIMEOUT_EN
        end else if (wait_cnt_q == LAST_WAIT) begin
          rsp_valid_d  = 1'b1;
          rsp_slverr_d = 1'b1;
          rsp_rdata_d  = '0;
          state_d      = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      pwrite_d = req_write;
      paddr_d  = req_addr;
      pwdata_d = req_write ? req_wdata : '0;
    end
    // Bus strobes are registered copies of the state being entered.
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  // State and output registers; reset clears every output, including the bus fields.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q      <= IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: directed APB sequences with a response scoreboard.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          pclk = 1'b0;
  logic          preset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_slverr;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          slverr;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic request(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic bus(input string tag, input logic s, input logic e);
    check({tag, "_psel"}, 64'(psel), 64'(s));
    check({tag, "_penable"}, 64'(penable), 64'(e));
  endtask

  // Scoreboard: every response pulse must match the oldest expected response.
  always @(negedge pclk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(1), 64'(0));
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_slverr", 64'(rsp_slverr), 64'(e.slverr));
      end
    end
  end

  initial begin
    preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    preset = 1'b0;
    bus("por", 1'b0, 1'b0);
    check("por_rsp_valid", 64'(rsp_valid), 64'(0));
    check("por_req_ready", 64'(req_ready), 64'(1));

    // Zero-wait write
    pready = 1'b1;
    request(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    exp_q.push_back('{rdata: '0, slverr: 1'b0});
    tick();
    req_valid = 1'b0;
    bus("wr_setup", 1'b1, 1'b0);
    check("wr_paddr", 64'(paddr), 64'h10);
    check("wr_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    tick();
    bus("wr_access", 1'b1, 1'b1);
    check("wr_pwrite", 64'(pwrite), 64'(1));
    tick();
    check("wr_rsp_valid", 64'(rsp_valid), 64'(1));
    bus("wr_idle", 1'b0, 1'b0);
    tick();
    check("wr_rsp_pulse", 64'(rsp_valid), 64'(0));

    // Read with three wait states
    pready = 1'b0;
    request(1'b0, 32'h20, 32'h5555_5555);
    exp_q.push_back('{rdata: 32'h1234_5678, slverr: 1'b0});
    tick();
    req_valid = 1'b0;
    check("rd_pwdata_zero", 64'(pwdata), 64'(0));
    tick();
    for (int i = 0; i < 3; i++) begin
      bus("rd_wait", 1'b1, 1'b1);
      check("rd_paddr_stable", 64'(paddr), 64'h20);
      check("rd_req_ready", 64'(req_ready), 64'(0));
      check("rd_no_rsp", 64'(rsp_valid), 64'(0));
      tick();
    end
    pready = 1'b1;
    prdata = 32'h1234_5678;
    check("rd_paddr_last", 64'(paddr), 64'h20);
    tick();
    check("rd_rsp_valid", 64'(rsp_valid), 64'(1));
    prdata = '0;

    // Back-to-back write then read
    request(1'b1, 32'h4, 32'hA5A5_A5A5);
    exp_q.push_back('{rdata: '0, slverr: 1'b0});
    tick();
    bus("b2b_setup1", 1'b1, 1'b0);
    request(1'b0, 32'h8, 32'h0);
    prdata = 32'hCAFE_0008;
    exp_q.push_back('{rdata: 32'hCAFE_0008, slverr: 1'b0});
    tick();
    bus("b2b_access1", 1'b1, 1'b1);
    check("b2b_pwrite1", 64'(pwrite), 64'(1));
    tick();
    req_valid = 1'b0;
    bus("b2b_setup2", 1'b1, 1'b0);
    check("b2b_rsp1", 64'(rsp_valid), 64'(1));
    check("b2b_paddr2", 64'(paddr), 64'h8);
    check("b2b_pwrite2", 64'(pwrite), 64'(0));
    tick();
    bus("b2b_access2", 1'b1, 1'b1);
    check("b2b_gap", 64'(rsp_valid), 64'(0));
    tick();
    bus("b2b_idle", 1'b0, 1'b0);
    check("b2b_rsp2", 64'(rsp_valid), 64'(1));

    // Slave error, then a clean transfer with pslverr high only while waiting
    pslverr = 1'b1;
    prdata  = 32'h0BAD_0FFC;
    request(1'b0, 32'hFFC, 32'h0);
    exp_q.push_back('{rdata: 32'h0BAD_0FFC, slverr: 1'b1});
    tick(); req_valid = 1'b0;
    tick(); tick();
    check("err_rsp_slverr", 64'(rsp_slverr), 64'(1));
    pready = 1'b0;
    request(1'b1, 32'h30, 32'h0000_0030);
    exp_q.push_back('{rdata: '0, slverr: 1'b0});
    tick(); req_valid = 1'b0;
    tick(); tick();
    pready = 1'b1; pslverr = 1'b0;
    tick();
    check("err_next_valid", 64'(rsp_valid), 64'(1));
    check("err_next_slverr", 64'(rsp_slverr), 64'(0));

`ifdef APB_TIMEOUT_EN
    // Stuck slave: abort after four ACCESS cycles
    pready = 1'b0;
    request(1'b0, 32'h50, 32'h0);
    exp_q.push_back('{rdata: '0, slverr: 1'b1});
    tick(); req_valid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      bus("to_access", 1'b1, 1'b1);
      check("to_req_ready", 64'(req_ready), 64'(0));
      tick();
    end
    bus("to_abort", 1'b0, 1'b0);
    check("to_rsp_valid", 64'(rsp_valid), 64'(1));
    pready = 1'b1;
    request(1'b1, 32'h60, 32'h6);
    exp_q.push_back('{rdata: '0, slverr: 1'b0});
    check("to_next_ready", 64'(req_ready), 64'(1));
    tick(); req_valid = 1'b0;
    bus("to_next_setup", 1'b1, 1'b0);
    tick(); tick();
    check("to_next_rsp", 64'(rsp_valid), 64'(1));
`endif

    // Reset in the middle of ACCESS: no response may appear
    pready = 1'b0;
    request(1'b1, 32'h40, 32'h4444_4444);
    tick(); req_valid = 1'b0;
    tick();
    bus("rst_pre", 1'b1, 1'b1);
    preset = 1'b1;
    tick();
    bus("rst_first", 1'b0, 1'b0);
    check("rst_pwrite", 64'(pwrite), 64'(0));
    check("rst_paddr", 64'(paddr), 64'(0));
    check("rst_pwdata", 64'(pwdata), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    tick();
    preset = 1'b0;
    check("rst_idle_ready", 64'(req_ready), 64'(1));
    for (int i = 0; i < 4; i++) tick();
    bus("rst_after", 1'b0, 1'b0);

    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors %0d", n_errors);
    $fatal(1);
  end

endmodule
